pic10_fetch: RTL and testbench

Instruction fetch and sequencing stage of the PIC10 core, directly upstream of the ALU. Owns the program counter, the 12-bit instruction register and the four-phase Q1–Q4 instruction-cycle sequencer. Drives program ROM addresses and presents the latched instruction on `ir_reg_bus`, which the ALU and decode logic consume. Accepts PC-load and skip requests from execute and flushes the pipeline with a NOP when either is taken.

---
 rtl/pic10_fetch_if.sv | 38 +++
 rtl/pic10_fetch.sv | 73 +++++++
 tb/tb_pic10_fetch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pic10_fetch_if.sv
// PIC10 fetch-stage bus: ROM port, execute requests and sequencer outputs.
// master = fetch stage, slave = ROM/execute side. hold with PIC10_FETCH_HOLD_EN.
interface pic10_fetch_if #(
  parameter int PC_WIDTH = 9
);
  logic [11:0]         rom_data;
  logic                load_pc;
  logic [PC_WIDTH-1:0] pc_load_value;
  logic                skip;
`ifdef PIC10_FETCH_HOLD_EN
  logic                hold;
`endif
  logic [PC_WIDTH-1:0] rom_addr;
  logic [PC_WIDTH-1:0] pc_bus;
  logic [11:0]         ir_reg_bus;
  logic [1:0]          q_phase;
  logic                cycle_end;

`ifdef PIC10_FETCH_HOLD_EN
  modport master (
    input  rom_data, load_pc, pc_load_value, skip, hold,
    output rom_addr, pc_bus, ir_reg_bus, q_phase, cycle_end
  );
  modport slave (
    output rom_data, load_pc, pc_load_value, skip, hold,
    input  rom_addr, pc_bus, ir_reg_bus, q_phase, cycle_end
  );
`else
  modport master (
    input  rom_data, load_pc, pc_load_value, skip,
    output rom_addr, pc_bus, ir_reg_bus, q_phase, cycle_end
  );
  modport slave (
    output rom_data, load_pc, pc_load_value, skip,
    input  rom_addr, pc_bus, ir_reg_bus, q_phase, cycle_end
  );
`endif
endinterface

// File: rtl/pic10_fetch.sv
// PIC10 fetch stage: PC, IR and Q1-Q4 sequencer; NOP flush on load_pc/skip.
// Ports: clk, rst_n (sync, active low), bus (pic10_fetch_if.master).
// Optional: PIC10_FETCH_HOLD_EN adds bus.hold to freeze the sequencer.
module pic10_fetch #(
  parameter int                  PC_WIDTH     = 9,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1,
  parameter logic [11:0]         NOP_OPCODE   = 12'h000
) (
  input logic           clk,
  input logic           rst_n,
  pic10_fetch_if.master bus
);

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [11:0]         ir_q, ir_d;
  logic                run;

`ifdef PIC10_FETCH_HOLD_EN
  assign run = ~bus.hold;
`else
  assign run = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= Q1;
      pc_q    <= RESET_VECTOR;
      ir_q    <= NOP_OPCODE;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Execute requests only matter on the edge that closes Q4;
  // a load takes precedence over a simultaneous skip.
  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (run) begin
      phase_d = phase_e'(phase_q + 2'd1);
      if (phase_q == Q4) begin
        if (bus.load_pc) begin
          ir_d = NOP_OPCODE;
          pc_d = bus.pc_load_value;
        end else if (bus.skip) begin
          ir_d = NOP_OPCODE;
          pc_d = pc_q + 1'b1;
        end else begin
          ir_d = bus.rom_data;
          pc_d = pc_q + 1'b1;
        end
      end
    end
  end

  assign bus.rom_addr   = pc_q;
  assign bus.pc_bus     = pc_q;
  assign bus.ir_reg_bus = ir_q;
  assign bus.q_phase    = phase_q;
  assign bus.cycle_end  = (phase_q == Q4);

endmodule

// File: tb/tb_pic10_fetch.sv
// Directed testbench for pic10_fetch.
// Drives/samples on negedge; ROM modelled as an array.
module tb_pic10_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [11:0] rom [512];

  pic10_fetch_if #(.PC_WIDTH(9)) bus ();

  pic10_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic chk(input string name, input logic [11:0] act,
                     input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.pc_bus !== 9'h1FF) begin
      bad++; $display("FAIL rst_pc: got %h want 1ff", bus.pc_bus);
    end
    total++;
    if (bus.ir_reg_bus !== 12'h000) begin
      bad++; $display("FAIL rst_ir: got %h want 000", bus.ir_reg_bus);
    end
    total++;
    if (bus.q_phase !== 2'd0 || bus.cycle_end !== 1'b0) begin
      bad++;
      $display("FAIL rst_q: got q=%0d ce=%b want 0/0",
               bus.q_phase, bus.cycle_end);
    end
    total++;
    if (bus.rom_addr !== 9'h1FF) begin
      bad++; $display("FAIL rst_addr: got %h want 1ff", bus.rom_addr);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.q_phase !== 2'd3 || bus.cycle_end !== 1'b1
        || bus.ir_reg_bus !== 12'h000) begin
      bad++;
      $display("FAIL first_q4: got q=%0d ce=%b ir=%h want 3/1/000",
               bus.q_phase, bus.cycle_end, bus.ir_reg_bus);
    end
    @(negedge clk);
    total++;
    if (bus.ir_reg_bus !== 12'hC05 || bus.pc_bus !== 9'h000) begin
      bad++;
      $display("FAIL first_ir: got ir=%h pc=%h want c05/000",
               bus.ir_reg_bus, bus.pc_bus);
    end
  endtask

  task automatic test_sequential();
    logic [11:0] exp [3];
    logic [11:0] prev;
    int ce;
    exp[0] = 12'h1C1; exp[1] = 12'h0A3; exp[2] = 12'hC7F;
    prev = 12'hC05;
    for (int k = 0; k < 3; k++) begin
      ce = 0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (bus.cycle_end) ce++;
        if (j < 3 && bus.ir_reg_bus !== prev) begin
          total++; bad++;
          $display("FAIL seq_hold%0d: got %h want %h", k,
                   bus.ir_reg_bus, prev);
        end
      end
      total++;
      if (ce != 1) begin
        bad++; $display("FAIL seq_ce%0d: got %0d want 1", k, ce);
      end
      total++;
      if (bus.ir_reg_bus !== exp[k]) begin
        bad++;
        $display("FAIL seq_ir%0d: got %h want %h", k, bus.ir_reg_bus, exp[k]);
      end
      total++;
      if (bus.pc_bus !== 9'(k + 1)) begin
        bad++;
        $display("FAIL seq_pc%0d: got %h want %h", k, bus.pc_bus, k + 1);
      end
      prev = exp[k];
    end
  endtask

  task automatic to_q4(input string name);
    repeat (3) @(negedge clk);
    total++;
    if (bus.q_phase !== 2'd3) begin
      bad++; $display("FAIL %s_q4: got %0d want 3", name, bus.q_phase);
    end
  endtask

  task automatic test_branch();
    to_q4("br");
    bus.load_pc = 1'b1; bus.pc_load_value = 9'h040;
    @(negedge clk);
    bus.load_pc = 1'b0;
    chk("br_ir", bus.ir_reg_bus, 12'h000);
    chk("br_pc", {3'b0, bus.pc_bus}, 12'h040);
    repeat (4) @(negedge clk);
    chk("br_tgt_ir", bus.ir_reg_bus, 12'h840);
    chk("br_tgt_pc", {3'b0, bus.pc_bus}, 12'h041);
  endtask

  task automatic test_skip_vs_load();
    to_q4("sl");
    bus.load_pc = 1'b1; bus.skip = 1'b1; bus.pc_load_value = 9'h010;
    @(negedge clk);
    bus.load_pc = 1'b0; bus.skip = 1'b0;
    chk("both_pc", {3'b0, bus.pc_bus}, 12'h010);
    chk("both_ir", bus.ir_reg_bus, 12'h000);
    to_q4("sl2");
    bus.load_pc = 1'b1; bus.pc_load_value = 9'h005;
    @(negedge clk);
    bus.load_pc = 1'b0;
    chk("ld5_pc", {3'b0, bus.pc_bus}, 12'h005);
    to_q4("sk");
    bus.skip = 1'b1;
    @(negedge clk);
    bus.skip = 1'b0;
    chk("skip_ir", bus.ir_reg_bus, 12'h000);
    chk("skip_pc", {3'b0, bus.pc_bus}, 12'h006);
    repeat (4) @(negedge clk);
    chk("after_skip_ir", bus.ir_reg_bus, 12'h806);
    chk("after_skip_pc", {3'b0, bus.pc_bus}, 12'h007);
  endtask

  task automatic test_ignored_wrap();
    @(negedge clk);
    bus.skip = 1'b1;
    @(negedge clk);
    bus.skip = 1'b0;
    bus.load_pc = 1'b1; bus.pc_load_value = 9'h0AA;
    @(negedge clk);
    bus.load_pc = 1'b0;
    @(negedge clk);
    chk("ign_ir", bus.ir_reg_bus, 12'h807);
    chk("ign_pc", {3'b0, bus.pc_bus}, 12'h008);
    to_q4("wr");
    bus.load_pc = 1'b1; bus.pc_load_value = 9'h1FF;
    @(negedge clk);
    bus.load_pc = 1'b0;
    chk("wr_ld_pc", {3'b0, bus.pc_bus}, 12'h1FF);
    repeat (4) @(negedge clk);
    chk("wrap_pc", {3'b0, bus.pc_bus}, 12'h000);
    chk("wrap_ir", bus.ir_reg_bus, 12'hC05);
  endtask

`ifdef PIC10_FETCH_HOLD_EN
  task automatic test_hold();
    to_q4("hd");
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_q", {10'b0, bus.q_phase}, 12'h003);
      chk("hold_ce", {11'b0, bus.cycle_end}, 12'h001);
      chk("hold_pc", {3'b0, bus.pc_bus}, 12'h000);
      chk("hold_ir", bus.ir_reg_bus, 12'hC05);
    end
    bus.hold = 1'b0;
    @(negedge clk);
    chk("unhold_q", {10'b0, bus.q_phase}, 12'h000);
    chk("unhold_pc", {3'b0, bus.pc_bus}, 12'h001);
    chk("unhold_ir", bus.ir_reg_bus, 12'h1C1);
    @(negedge clk);
    bus.hold = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("hrst_pc", {3'b0, bus.pc_bus}, 12'h1FF);
    chk("hrst_ir", bus.ir_reg_bus, 12'h000);
    chk("hrst_q", {10'b0, bus.q_phase}, 12'h000);
    chk("hrst_ce", {11'b0, bus.cycle_end}, 12'h000);
    bus.hold = 1'b0; rst_n = 1'b1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 12'h800 | 12'(i);
    rom[9'h1FF] = 12'hC05;
    rom[9'h000] = 12'h1C1;
    rom[9'h001] = 12'h0A3;
    rom[9'h002] = 12'hC7F;
    bus.load_pc = 1'b0;
    bus.skip = 1'b0;
    bus.pc_load_value = 9'h000;
`ifdef PIC10_FETCH_HOLD_EN
    bus.hold = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_skip_vs_load();
    test_ignored_wrap();
`ifdef PIC10_FETCH_HOLD_EN
    test_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
